// File: rtl/add64_seq_pkg.sv
// add64_seq_pkg
// Shared definitions for the 64-bit add/sub/accumulate sequencer:
//   - opcode encodings (2-bit): OP_ADD, OP_SUB, OP_ACC, OP_CLR
//   - sequencer state enum: IDLE, LO, HI, DONE
//   - 64-bit saturation limits SAT_MAX / SAT_MIN, used only when the
//     ADD64_SAT_EN macro is defined
package add64_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LO   = 2'b01,
    HI   = 2'b10,
    DONE = 2'b11
  } state_t;

  localparam logic [63:0] SAT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_MIN = 64'h8000_0000_0000_0000;

endpackage

// File: rtl/add64_seq_ctrl.sv
// add64_seq_ctrl
// Sequences 64-bit ADD / SUB / ACC / CLR operations over an external,
// shared 32-bit adder. Each arithmetic op uses two adder passes: the low
// word first, then the high word with the carry latched from the low pass.
// The block also owns a 64-bit accumulator.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   in_valid/in_ready      request handshake; in_op, in_a, in_b operands
//   out_valid/out_ready    response handshake; out_res, out_carry, out_ovf
//   acc_q                  current accumulator value
//   adder_a/b/cin          drive the shared adder (all zero when not in use)
//   adder_sum/cout         results returned by the shared adder
//
// Build option: define ADD64_SAT_EN to saturate overflowing results to
// SAT_MAX / SAT_MIN instead of wrapping.
module add64_seq_ctrl
  import add64_seq_pkg::*;
#(
  parameter int OPW = 2,
  parameter int W   = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [2*W-1:0] in_a,
  input  logic [2*W-1:0] in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_res,
  output logic           out_carry,
  output logic           out_ovf,
  output logic [2*W-1:0] acc_q,
  output logic [W-1:0]   adder_a,
  output logic [W-1:0]   adder_b,
  output logic           adder_cin,
  input  logic [W-1:0]   adder_sum,
  input  logic           adder_cout
);

  localparam int DW = 2 * W;

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  opa_q, opa_d;
  logic [DW-1:0]  beff_q, beff_d;
  logic [W-1:0]   res_lo_q, res_lo_d;
  logic           c_lo_q, c_lo_d;
  logic [DW-1:0]  out_res_q, out_res_d;
  logic           out_carry_q, out_carry_d;
  logic           out_ovf_q, out_ovf_d;
  logic [DW-1:0]  acc_d;

  logic [DW-1:0]  res_raw;
  logic [DW-1:0]  res_fin;
  logic           ovf_w;

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      opa_q       <= '0;
      beff_q      <= '0;
      res_lo_q    <= '0;
      c_lo_q      <= 1'b0;
      out_res_q   <= '0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opa_q       <= opa_d;
      beff_q      <= beff_d;
      res_lo_q    <= res_lo_d;
      c_lo_q      <= c_lo_d;
      out_res_q   <= out_res_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
      acc_q       <= acc_d;
    end
  end

  // Next-state and datapath logic. The adder inputs default to zero so the
  // shared adder stays quiet in IDLE and DONE.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    opa_d       = opa_q;
    beff_d      = beff_q;
    res_lo_d    = res_lo_q;
    c_lo_d      = c_lo_q;
    out_res_d   = out_res_q;
    out_carry_d = out_carry_q;
    out_ovf_d   = out_ovf_q;
    acc_d       = acc_q;
    adder_a     = '0;
    adder_b     = '0;
    adder_cin   = 1'b0;
    res_raw     = '0;
    res_fin     = '0;
    ovf_w       = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d = in_op;
          // SUB adds the inverted B with carry-in 1; ACC adds in_a to acc.
          case (in_op)
            OP_ADD: begin
              opa_d   = in_a;
              beff_d  = in_b;
              state_d = LO;
            end
            OP_SUB: begin
              opa_d   = in_a;
              beff_d  = ~in_b;
              state_d = LO;
            end
            OP_ACC: begin
              opa_d   = acc_q;
              beff_d  = in_a;
              state_d = LO;
            end
            default: begin
              acc_d       = '0;
              out_res_d   = '0;
              out_carry_d = 1'b0;
              out_ovf_d   = 1'b0;
              state_d     = DONE;
            end
          endcase
        end
      end

      LO: begin
        adder_a   = opa_q[W-1:0];
        adder_b   = beff_q[W-1:0];
        adder_cin = (op_q == OP_SUB);
        res_lo_d  = adder_sum;
        c_lo_d    = adder_cout;
        state_d   = HI;
      end

      HI: begin
        adder_a   = opa_q[DW-1:W];
        adder_b   = beff_q[DW-1:W];
        adder_cin = c_lo_q;
        res_raw   = {adder_sum, res_lo_q};
        // Signed overflow: like-signed operands produced an unlike-signed sum.
        ovf_w     = (opa_q[DW-1] == beff_q[DW-1]) && (res_raw[DW-1] != opa_q[DW-1]);
`ifdef ADD64_SAT_EN
        res_fin   = ovf_w ? (opa_q[DW-1] ? SAT_MIN : SAT_MAX) : res_raw;
`else
        res_fin   = res_raw;
`endif
        out_res_d   = res_fin;
        out_carry_d = adder_cout;
        out_ovf_d   = ovf_w;
        if (op_q == OP_ACC) begin
          acc_d = res_fin;
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_res   = out_res_q;
  assign out_carry = out_carry_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_add64_seq_ctrl.sv
// tb_add64_seq_ctrl
// Self-checking bench for add64_seq_ctrl, wired to a plain 32-bit adder.
// A fixed vector table covers the directed cases, hand-written sequences
// cover held requests and reset during an op, and a randomized loop is
// compared against a 64-bit arithmetic reference model.
module tb_add64_seq_ctrl;
  import add64_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_res;
  logic        out_carry;
  logic        out_ovf;
  logic [63:0] acc_q;
  logic [31:0] adder_a;
  logic [31:0] adder_b;
  logic        adder_cin;
  logic [31:0] adder_sum;
  logic        adder_cout;

  int numChecks = 0;
  int numPassed = 0;

  logic [63:0] modelAcc = '0;
  logic [63:0] gotRes;
  logic        gotCarry;
  logic        gotOvf;
  int          gotLat;
  logic        loCin;
  logic        loCout;
  logic        hiCin;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] expRes;
    logic        expCarry;
    logic        expOvf;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  // Shared 32-bit adder that the sequencer drives.
  assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {32'b0, adder_cin};

  add64_seq_ctrl #(.OPW(2), .W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_carry  (out_carry),
    .out_ovf    (out_ovf),
    .acc_q      (acc_q),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout)
  );

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    numChecks++;
    if (actual === expected) begin
      numPassed++;
    end else begin
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Reference model: plain 64-bit two's-complement arithmetic.
  function automatic void refModel(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                   output logic [63:0] res, output logic c, output logic o);
    logic [64:0] wide;
    logic [63:0] x;
    x = a;
    if (op == OP_CLR) begin
      res = '0;
      c = 1'b0;
      o = 1'b0;
      modelAcc = '0;
    end else if (op == OP_SUB) begin
      res = a - b;
      c = (a >= b);
      o = (a[63] != b[63]) && (res[63] != a[63]);
    end else begin
      if (op == OP_ACC) begin
        x = modelAcc;
        wide = {1'b0, modelAcc} + {1'b0, a};
        o = (modelAcc[63] == a[63]) && (wide[63] != modelAcc[63]);
      end else begin
        wide = {1'b0, a} + {1'b0, b};
        o = (a[63] == b[63]) && (wide[63] != a[63]);
      end
      res = wide[63:0];
      c = wide[64];
    end
`ifdef ADD64_SAT_EN
    if (o) res = x[63] ? SAT_MIN : SAT_MAX;
`else
    if (o) x = x;
`endif
    if (op == OP_ACC) modelAcc = res;
  endfunction

  // Issues one request, waits for the result and holds out_ready low for
  // holdCycles cycles before consuming it.
  task automatic applyStimulus(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input int holdCycles);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkOutput("ready_timeout", 64'(in_ready), 64'd1);
    checkOutput("idle_adder", 64'(adder_a) | 64'(adder_b) | 64'(adder_cin), 64'd0);
    in_op = op;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    loCin = adder_cin;
    loCout = adder_cout;
    hiCin = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) hiCin = adder_cin;
    end
    gotLat = n;
    if (!out_valid) checkOutput("valid_timeout", 64'(out_valid), 64'd1);
    gotRes = out_res;
    gotCarry = out_carry;
    gotOvf = out_ovf;
    for (int i = 0; i < holdCycles; i++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_res", out_res, gotRes);
      checkOutput("hold_valid_ready", 64'({out_valid, in_ready}), 64'b10);
    end
    checkOutput("done_adder", 64'(adder_a) | 64'(adder_b) | 64'(adder_cin), 64'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("release_valid_ready", 64'({out_valid, in_ready}), 64'b01);
  endtask

  // Runs one op and compares all results against the reference model.
  task automatic runModelOp(input string tag, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b, input int holdCycles);
    logic [63:0] eRes;
    logic eC;
    logic eO;
    refModel(op, a, b, eRes, eC, eO);
    applyStimulus(op, a, b, holdCycles);
    checkOutput({tag, "_res"}, gotRes, eRes);
    checkOutput({tag, "_carry"}, 64'(gotCarry), 64'(eC));
    checkOutput({tag, "_ovf"}, 64'(gotOvf), 64'(eO));
    checkOutput({tag, "_acc"}, acc_q, modelAcc);
    checkOutput({tag, "_lat"}, 64'(gotLat), (op == OP_CLR) ? 64'd0 : 64'd2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  rOp;
    logic [63:0] rA;
    logic [63:0] rB;

    vecs[0] = '{OP_ADD, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0001_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{OP_SUB, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{OP_SUB, 64'd7, 64'd5, 64'd2, 1'b1, 1'b0};
`ifdef ADD64_SAT_EN
    vecs[3] = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
`else
    vecs[3] = '{OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
`endif
    vecs[4] = '{OP_CLR, 64'h1234, 64'h5678, 64'd0, 1'b0, 1'b0};
    vecs[5] = '{OP_ACC, 64'd10, 64'hDEAD, 64'd10, 1'b0, 1'b0};
    vecs[6] = '{OP_ACC, 64'd10, 64'hBEEF, 64'd20, 1'b0, 1'b0};
    vecs[7] = '{OP_ACC, 64'd10, 64'hFFFF, 64'd30, 1'b0, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_op = OP_ADD;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    #23;
    checkOutput("reset_out", out_res | 64'({out_valid, out_carry, out_ovf}), 64'd0);
    checkOutput("reset_acc", acc_q, 64'd0);
    checkOutput("reset_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_adder", 64'(adder_a) | 64'(adder_b) | 64'(adder_cin), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      logic [63:0] eRes;
      logic eC;
      logic eO;
      refModel(vecs[i].op, vecs[i].a, vecs[i].b, eRes, eC, eO);
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, (vecs[i].op == OP_ACC) ? 5 : 0);
      checkOutput($sformatf("vec%0d_res", i), gotRes, vecs[i].expRes);
      checkOutput($sformatf("vec%0d_carry", i), 64'(gotCarry), 64'(vecs[i].expCarry));
      checkOutput($sformatf("vec%0d_ovf", i), 64'(gotOvf), 64'(vecs[i].expOvf));
      checkOutput($sformatf("vec%0d_acc", i), acc_q, modelAcc);
      checkOutput($sformatf("vec%0d_lat", i), 64'(gotLat), (vecs[i].op == OP_CLR) ? 64'd0 : 64'd2);
      if (vecs[i].op == OP_ACC) checkOutput($sformatf("vec%0d_res_eq_acc", i), gotRes, acc_q);
      if (i == 0) begin
        checkOutput("add_lo_cin", 64'(loCin), 64'd0);
        checkOutput("add_lo_cout", 64'(loCout), 64'd1);
        checkOutput("add_hi_cin", 64'(hiCin), 64'd1);
      end
    end
    checkOutput("acc_after_three", acc_q, 64'd30);

    // Request held through busy states is accepted once, operands latched
    @(negedge clk);
    in_op = OP_ADD;
    in_a = 64'd1;
    in_b = 64'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_a = 64'd100;
    checkOutput("held_busy_lo", 64'({in_ready, out_valid}), 64'b00);
    @(posedge clk);
    #1;
    checkOutput("held_busy_hi", 64'({in_ready, out_valid}), 64'b00);
    @(posedge clk);
    #1;
    checkOutput("held_done", 64'({in_ready, out_valid}), 64'b01);
    checkOutput("held_res", out_res, 64'd2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("held_release", 64'({in_ready, out_valid}), 64'b10);

    // Reset asserted while an ACC op is in HI
    @(negedge clk);
    in_op = OP_ACC;
    in_a = 64'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_acc", acc_q, 64'd0);
    checkOutput("midrst_valid_ready", 64'({out_valid, in_ready}), 64'b01);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postrst_acc", acc_q, 64'd0);
    checkOutput("postrst_valid_ready", 64'({out_valid, in_ready}), 64'b01);
    modelAcc = '0;
    runModelOp("postrst_add", OP_ADD, 64'd2, 64'd3, 0);
    checkOutput("postrst_add_five", gotRes, 64'd5);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      rOp = 2'($urandom_range(0, 3));
      rA = {$urandom, $urandom};
      rB = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rA = {1'b0, {63{1'b1}}};
      if ($urandom_range(0, 3) == 0) rB = {1'b1, 63'($urandom)};
      if (rOp == OP_CLR && $urandom_range(0, 1) == 0) rOp = OP_ACC;
      runModelOp($sformatf("rnd%0d", i), rOp, rA, rB, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d/%0d checks passed", numPassed, numChecks);
    $finish;
  end

endmodule
